// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types, constants and helpers for the framebuffer pattern writer
package fb_pkg;

  typedef enum logic [1:0] {
    PAT_VSTRIPE  = 2'd0,
    PAT_HSTRIPE  = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam int BYTES_PER_PIXEL = 4;
  localparam logic [31:0] PIX_WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] PIX_BLACK = 32'h0000_0000;

  // Byte address of the bottom-right pixel of a hdisp x vdisp frame.
  function automatic logic [31:0] fb_last_adr(input int hdisp, input int vdisp);
    return 32'(hdisp * vdisp * BYTES_PER_PIXEL - BYTES_PER_PIXEL);
  endfunction

endpackage

// File: rtl/wshb_if.sv
// rtl/wshb_if.sv - classic Wishbone bus bundle with master and slave views
interface wshb_if;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        stb;
  logic        cyc;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (output adr, dat_ms, stb, cyc, we, sel, cti, bte, input dat_sm, ack);
  modport slave  (input adr, dat_ms, stb, cyc, we, sel, cti, bte, output dat_sm, ack);
endinterface

// File: rtl/fb_pattern_writer_pattern_gen.sv
// rtl/fb_pattern_writer_pattern_gen.sv - combinational (x, y, pattern) to pixel word
module pattern_gen
  import fb_pkg::*;
#(
  parameter int XW          = 10,
  parameter int YW          = 9,
  parameter int STRIPE_LOG2 = 4
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  pattern_e      pat_i,
  output logic [31:0]   pixel_o
);

  // Coordinates are widened so stripe bits beyond the counter width read as 0.
  logic [15:0] xe;
  logic [15:0] ye;
  logic [15:0] sum;
  logic        xb;
  logic        yb;
  logic        unused_bits;

  always_comb begin
    xe      = 16'(x_i);
    ye      = 16'(y_i);
    sum     = xe + ye;
    xb      = xe[STRIPE_LOG2];
    yb      = ye[STRIPE_LOG2];
    pixel_o = PIX_BLACK;
    unique case (pat_i)
      PAT_VSTRIPE:  pixel_o = xb ? PIX_WHITE : PIX_BLACK;
      PAT_HSTRIPE:  pixel_o = yb ? PIX_WHITE : PIX_BLACK;
      PAT_CHECKER:  pixel_o = (xb ^ yb) ? PIX_WHITE : PIX_BLACK;
      PAT_GRADIENT: pixel_o = {8'h00, xe[7:0], ye[7:0], sum[8:1]};
      default:      pixel_o = PIX_BLACK;
    endcase
  end

  assign unused_bits = ^{xe, ye, sum};

endmodule

// File: rtl/fb_pattern_writer.sv
// rtl/fb_pattern_writer.sv - Wishbone master filling the framebuffer with a test pattern
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int HDISP        = 800,
  parameter int VDISP        = 480,
  parameter int BURST_LEN    = 64,
  parameter int PAUSE_CYCLES = 16,
  parameter int STRIPE_LOG2  = 4
) (
  input  logic       wshb_clk,
  input  logic       wshb_rst_n,
  wshb_if.master     wshb_ifm,
  input  logic       start,
  input  logic       continuous,
  input  logic [1:0] pattern_sel,
  output logic       busy,
  output logic       frame_done
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST_LEN);
  localparam int PW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [31:0] LAST_ADR = fb_last_adr(HDISP, VDISP);

  state_e        state_q;
  pattern_e      pat_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [BW-1:0] burst_q;
  logic [PW-1:0] pause_q;
  logic          cyc_q;
  logic          busy_q;
  logic          done_q;
  logic          frame_end_q;

  logic          ack;
  logic          last_pix;
  logic          x_wrap;
  logic [XW-1:0] x_adv;
  logic [YW-1:0] y_adv;
  logic [XW-1:0] gen_x;
  logic [YW-1:0] gen_y;
  pattern_e      gen_pat;
  logic [31:0]   gen_pixel;
  logic          unused_dat_sm;

  // The pixel generator always looks at the coordinates of the next word put on the bus.
  always_comb begin
    ack      = wshb_ifm.ack && cyc_q;
    last_pix = (adr_q == LAST_ADR);
    x_wrap   = (x_q == XW'(HDISP - 1));
    x_adv    = x_wrap ? '0 : x_q + 1'b1;
    y_adv    = y_q;
    if (x_wrap) begin
      y_adv = (y_q == YW'(VDISP - 1)) ? '0 : y_q + 1'b1;
    end
    gen_x   = x_q;
    gen_y   = y_q;
    gen_pat = pat_q;
    case (state_q)
      IDLE:    gen_pat = pattern_e'(pattern_sel);
      WRITE: begin
        gen_x = x_adv;
        gen_y = y_adv;
      end
      PAUSE:   if (frame_end_q) gen_pat = pattern_e'(pattern_sel);
      default: gen_pat = pat_q;
    endcase
  end

  pattern_gen #(
    .XW          (XW),
    .YW          (YW),
    .STRIPE_LOG2 (STRIPE_LOG2)
  ) u_pattern_gen (
    .x_i     (gen_x),
    .y_i     (gen_y),
    .pat_i   (gen_pat),
    .pixel_o (gen_pixel)
  );

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state_q     <= IDLE;
      pat_q       <= PAT_VSTRIPE;
      x_q         <= '0;
      y_q         <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      burst_q     <= '0;
      pause_q     <= '0;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WRITE;
            cyc_q   <= 1'b1;
            busy_q  <= 1'b1;
            pat_q   <= gen_pat;
            dat_q   <= gen_pixel;
          end
        end
        WRITE: begin
          if (ack) begin
            x_q     <= x_adv;
            y_q     <= y_adv;
            dat_q   <= gen_pixel;
            if (last_pix) begin
              adr_q       <= '0;
              done_q      <= 1'b1;
              burst_q     <= '0;
              pause_q     <= '0;
              cyc_q       <= 1'b0;
              frame_end_q <= 1'b1;
              if (continuous) begin
                state_q <= PAUSE;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              adr_q <= adr_q + 32'(BYTES_PER_PIXEL);
              if (burst_q == BW'(BURST_LEN - 1)) begin
                burst_q     <= '0;
                pause_q     <= '0;
                cyc_q       <= 1'b0;
                frame_end_q <= 1'b0;
                state_q     <= PAUSE;
              end else begin
                burst_q <= burst_q + 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (frame_end_q && !continuous) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (pause_q == PW'(PAUSE_CYCLES - 1)) begin
            state_q <= WRITE;
            cyc_q   <= 1'b1;
            dat_q   <= gen_pixel;
            pat_q   <= gen_pat;
          end else begin
            pause_q <= pause_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = dat_q;
  assign wshb_ifm.cyc    = cyc_q;
  assign wshb_ifm.stb    = cyc_q;
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign unused_dat_sm   = ^wshb_ifm.dat_sm;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb/tb_fb_pattern_writer.sv - self-checking bench for fb_pattern_writer
module tb_fb_pattern_writer;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_b, rst_s, start_b, start_s, cont_b, cont_s;
  logic [1:0] psel_b, psel_s;
  logic       busy_b, busy_s, done_b, done_s;

  wshb_if ifb();
  wshb_if ifs();

  fb_pattern_writer u_big (
    .wshb_clk (clk), .wshb_rst_n (rst_b), .wshb_ifm (ifb), .start (start_b),
    .continuous (cont_b), .pattern_sel (psel_b), .busy (busy_b), .frame_done (done_b)
  );

  fb_pattern_writer #(
    .HDISP (8), .VDISP (4), .BURST_LEN (64), .PAUSE_CYCLES (16), .STRIPE_LOG2 (1)
  ) u_small (
    .wshb_clk (clk), .wshb_rst_n (rst_s), .wshb_ifm (ifs), .start (start_s),
    .continuous (cont_s), .pattern_sel (psel_s), .busy (busy_s), .frame_done (done_s)
  );

  int  cycle = 0;
  int  checks = 0;
  int  errors = 0;
  int  max_delay = 0;
  int  sw_wait = 0;
  int  done_cnt = 0;
  int  done_cyc = -1;
  int  fall_cyc = -1;
  wr_t wlog_b[$];
  wr_t wlog_s[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Reference pixel from the pattern rules, in plain integer arithmetic.
  function automatic logic [31:0] ref_pix(input int x, input int y, input int pat, input int s);
    int xb, yb;
    xb = (x / (1 << s)) % 2;
    yb = (y / (1 << s)) % 2;
    case (pat)
      0:       return (xb == 1) ? 32'h00FFFFFF : 32'h0;
      1:       return (yb == 1) ? 32'h00FFFFFF : 32'h0;
      2:       return (xb != yb) ? 32'h00FFFFFF : 32'h0;
      default: return 32'((x % 256) * 65536 + (y % 256) * 256 + ((x + y) / 2) % 256);
    endcase
  endfunction

  // Big DUT slave: acks every cycle the strobe is seen.
  initial begin
    wr_t e;
    ifb.ack = 1'b0;
    ifb.dat_sm = '0;
    forever begin
      @(negedge clk);
      ifb.ack = ifb.cyc & ifb.stb;
      if (ifb.ack) begin
        e.adr = ifb.adr; e.dat = ifb.dat_ms; e.cyc = cycle;
        wlog_b.push_back(e);
      end
    end
  end

  // Small DUT slave: random ack latency, also checks the request is held until ack.
  initial begin
    wr_t e;
    logic [31:0] hold_adr, hold_dat;
    bit fresh;
    fresh = 1;
    ifs.ack = 1'b0;
    ifs.dat_sm = '0;
    forever begin
      @(negedge clk);
      if (ifs.cyc && ifs.stb) begin
        if (fresh) begin
          hold_adr = ifs.adr; hold_dat = ifs.dat_ms; fresh = 0;
        end else begin
          checks++;
          if (ifs.adr !== hold_adr || ifs.dat_ms !== hold_dat) begin
            errors++;
            $display("FAIL hold_stable: adr=%h dat=%h, required adr=%h dat=%h", ifs.adr, ifs.dat_ms, hold_adr, hold_dat);
          end
        end
        if (sw_wait == 0) begin
          ifs.ack = 1'b1;
          e.adr = ifs.adr; e.dat = ifs.dat_ms; e.cyc = cycle;
          wlog_s.push_back(e);
          sw_wait = int'($urandom_range(max_delay, 0));
          fresh = 1;
        end else begin
          ifs.ack = 1'b0;
          sw_wait--;
        end
      end else begin
        ifs.ack = 1'b0;
        fresh = 1;
      end
    end
  end

  initial begin
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (done_s === 1'b1) begin done_cnt++; done_cyc = cycle; end
      if (prev_busy && busy_s === 1'b0) fall_cyc = cycle;
      prev_busy = (busy_s === 1'b1);
    end
  end

  task automatic clear_small(input int delay);
    wlog_s.delete();
    done_cnt = 0; done_cyc = -1; fall_cyc = -1;
    max_delay = delay;
  endtask

  task automatic pulse_start_s;
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
  endtask

  task automatic test_reset;
    rst_b = 0; rst_s = 0;
    repeat (3) @(negedge clk);
    rst_b = 1; rst_s = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks += 2;
      if (ifb.cyc !== 0 || ifb.stb !== 0 || busy_b !== 0 || done_b !== 0 || ifb.adr !== 0) begin
        errors++;
        $display("FAIL reset_big c%0d: cyc=%b stb=%b busy=%b done=%b adr=%h, required all 0", i, ifb.cyc, ifb.stb, busy_b, done_b, ifb.adr);
      end
      if (ifs.cyc !== 0 || ifs.stb !== 0 || busy_s !== 0 || done_s !== 0 || ifs.adr !== 0) begin
        errors++;
        $display("FAIL reset_small c%0d: cyc=%b stb=%b busy=%b done=%b adr=%h, required all 0", i, ifs.cyc, ifs.stb, busy_s, done_s, ifs.adr);
      end
    end
    checks++;
    if (ifb.we !== 1'b1 || ifb.sel !== 4'hF || ifb.cti !== 3'b0 || ifb.bte !== 2'b0) begin
      errors++;
      $display("FAIL const_outputs: we=%b sel=%h cti=%h bte=%h, required 1 f 0 0", ifb.we, ifb.sel, ifb.cti, ifb.bte);
    end
  endtask

  task automatic test_vstripe_burst;
    int low;
    low = 0;
    wlog_b.delete();
    psel_b = 2'd0;
    @(negedge clk); start_b = 1;
    @(negedge clk); start_b = 0;
    for (int i = 0; i < 400 && wlog_b.size() < 65; i++) begin
      @(negedge clk);
      if (!ifb.cyc) low++;
    end
    checks++;
    if (wlog_b.size() < 65) begin
      errors++;
      $display("FAIL vstripe_timeout: writes=%0d, required >=65", wlog_b.size());
    end else begin
      for (int i = 0; i < 65; i++) begin
        checks++;
        if (wlog_b[i].adr !== 32'(4 * i) || wlog_b[i].dat !== ref_pix(i, 0, 0, 4)) begin
          errors++;
          $display("FAIL vstripe_word%0d: adr=%h dat=%h, required adr=%h dat=%h", i, wlog_b[i].adr, wlog_b[i].dat, 4 * i, ref_pix(i, 0, 0, 4));
        end
      end
      checks += 2;
      if (low != 16) begin
        errors++;
        $display("FAIL burst_pause_len: cyc low %0d cycles, required 16", low);
      end
      if (wlog_b[64].cyc - wlog_b[63].cyc != 17) begin
        errors++;
        $display("FAIL burst_ack_gap: %0d, required 17", wlog_b[64].cyc - wlog_b[63].cyc);
      end
    end
    rst_b = 0;
  endtask

  task automatic test_single_frame;
    bit ok;
    clear_small(5);
    cont_s = 0; psel_s = 2'd2;
    pulse_start_s();
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy_s) begin ok = 1; break; end
    end
    repeat (30) @(negedge clk);
    checks += 4;
    if (!ok || wlog_s.size() != 32) begin
      errors++;
      $display("FAIL frame_count: busy_fell=%0d writes=%0d, required 1 and 32", ok, wlog_s.size());
    end
    if (wlog_s.size() == 0 || wlog_s[wlog_s.size()-1].adr !== 32'd124) begin
      errors++;
      $display("FAIL frame_last_adr: writes=%0d, required last adr 124", wlog_s.size());
    end
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL frame_done_count: %0d, required 1", done_cnt);
    end
    if (done_cyc < 0 || fall_cyc != done_cyc) begin
      errors++;
      $display("FAIL busy_vs_done: busy fell at %0d, done at %0d, required equal", fall_cyc, done_cyc);
    end
    for (int i = 0; i < wlog_s.size() && i < 32; i++) begin
      checks++;
      if (wlog_s[i].adr !== 32'(4 * i) || wlog_s[i].dat !== ref_pix(i % 8, i / 8, 2, 1)) begin
        errors++;
        $display("FAIL checker_pix%0d: adr=%h dat=%h, required adr=%h dat=%h", i, wlog_s[i].adr, wlog_s[i].dat, 4 * i, ref_pix(i % 8, i / 8, 2, 1));
      end
    end
  endtask

  task automatic test_continuous;
    bit ok;
    clear_small(0);
    cont_s = 1; psel_s = 2'd2;
    pulse_start_s();
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wlog_s.size() >= 16) psel_s = 2'd3;
      if (wlog_s.size() >= 40) cont_s = 0;
      if (wlog_s.size() >= 40 && !busy_s) begin ok = 1; break; end
    end
    repeat (30) @(negedge clk);
    checks += 3;
    if (!ok || wlog_s.size() != 64) begin
      errors++;
      $display("FAIL cont_count: ended=%0d writes=%0d, required 1 and 64", ok, wlog_s.size());
    end
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL cont_done_count: %0d, required 2", done_cnt);
    end
    if (wlog_s.size() >= 33 && (wlog_s[32].cyc - wlog_s[31].cyc != 17)) begin
      errors++;
      $display("FAIL frame_pause_gap: %0d, required 17", wlog_s[32].cyc - wlog_s[31].cyc);
    end
    for (int i = 0; i < wlog_s.size() && i < 64; i++) begin
      checks++;
      if (wlog_s[i].adr !== 32'(4 * (i % 32)) ||
          wlog_s[i].dat !== ref_pix((i % 32) % 8, (i % 32) / 8, (i < 32) ? 2 : 3, 1)) begin
        errors++;
        $display("FAIL cont_pix%0d: adr=%h dat=%h, required adr=%h dat=%h", i, wlog_s[i].adr, wlog_s[i].dat,
                 4 * (i % 32), ref_pix((i % 32) % 8, (i % 32) / 8, (i < 32) ? 2 : 3, 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    bit p1, p2, ok;
    clear_small(2);
    cont_s = 0; psel_s = 2'd3;
    pulse_start_s();
    p1 = 0; p2 = 0; ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      start_s = 0;
      if (!p1 && wlog_s.size() >= 10) begin start_s = 1; p1 = 1; end
      else if (!p2 && wlog_s.size() >= 20) begin start_s = 1; p2 = 1; end
      else if (p2 && !busy_s) begin ok = 1; break; end
    end
    start_s = 0;
    repeat (40) @(negedge clk);
    checks += 3;
    if (!ok || wlog_s.size() != 32) begin
      errors++;
      $display("FAIL b2b_count: ended=%0d writes=%0d, required 1 and 32", ok, wlog_s.size());
    end
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL b2b_done_count: %0d, required 1", done_cnt);
    end
    if (wlog_s.size() == 0 || wlog_s[wlog_s.size()-1].adr !== 32'd124 ||
        wlog_s[wlog_s.size()-1].dat !== ref_pix(7, 3, 3, 1)) begin
      errors++;
      $display("FAIL b2b_last_word: writes=%0d, required last adr 7c dat %h", wlog_s.size(), ref_pix(7, 3, 3, 1));
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    clear_small(5);
    cont_s = 0; psel_s = 2'd2;
    pulse_start_s();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk); #1;
      if (ifs.cyc && ifs.stb && !ifs.ack && sw_wait > 0 && wlog_s.size() > 3) begin ok = 1; break; end
    end
    #1 rst_s = 0;
    #1;
    checks++;
    if (!ok || ifs.cyc !== 0 || ifs.stb !== 0 || busy_s !== 0 || ifs.adr !== 0) begin
      errors++;
      $display("FAIL async_reset: found_pending=%0d cyc=%b stb=%b busy=%b adr=%h, required 1 0 0 0 0", ok, ifs.cyc, ifs.stb, busy_s, ifs.adr);
    end
    @(negedge clk); rst_s = 1;
    n = wlog_s.size();
    repeat (20) @(negedge clk);
    checks++;
    if (busy_s !== 0 || ifs.cyc !== 0 || ifs.adr !== 0 || wlog_s.size() != n) begin
      errors++;
      $display("FAIL post_reset_idle: busy=%b cyc=%b adr=%h new_writes=%0d, required 0 0 0 0", busy_s, ifs.cyc, ifs.adr, wlog_s.size() - n);
    end
    clear_small(0);
    psel_s = 2'd1;
    pulse_start_s();
    for (int i = 0; i < 50 && wlog_s.size() < 1; i++) @(negedge clk);
    checks++;
    if (wlog_s.size() < 1 || wlog_s[0].adr !== 32'd0 || wlog_s[0].dat !== ref_pix(0, 0, 1, 1)) begin
      errors++;
      $display("FAIL restart_after_reset: writes=%0d, required first adr 0 dat %h", wlog_s.size(), ref_pix(0, 0, 1, 1));
    end
    rst_s = 0;
  endtask

  initial begin
    rst_b = 0; rst_s = 0;
    start_b = 0; start_s = 0;
    cont_b = 0; cont_s = 0;
    psel_b = 0; psel_s = 0;
    test_reset();
    test_vstripe_burst();
    test_single_frame();
    test_continuous();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
